// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage CPU.
// Detects load-use and early-branch-operand hazards, then drives the
// PC / IF/ID enables, the ID/EX bubble and the IF/ID flush.
// A halt request freezes the front end. Saturating counters track
// stall cycles and flush cycles.
module hazard_ctrl #(
  parameter int DELAY_SLOT = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt_req,
  input  logic [4:0]       Rn_ID,
  input  logic [4:0]       Rm_ID,
  input  logic             useRn_ID,
  input  logic             useRm_ID,
  input  logic             early_ID,
  input  logic             taken_ID,
  input  logic [4:0]       Rd_EX,
  input  logic             RegWrite_EX,
  input  logic             MemRead_EX,
  input  logic [4:0]       Rd_MEM,
  input  logic             RegWrite_MEM,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_STALL_LU = 2'd1,
    S_STALL_BR = 2'd2,
    S_HALT     = 2'd3
  } state_t;

  localparam logic             FLUSH_EN = (DELAY_SLOT == 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [4:0]       XZR      = 5'd31;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             ex_wr, mem_wr, lu_haz, br_haz, flush_run;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Hazard detection and next-state decision; XZR never produces a value.
  always_comb begin
    ex_wr   = RegWrite_EX  & (Rd_EX  != XZR);
    mem_wr  = RegWrite_MEM & (Rd_MEM != XZR);
    lu_haz  = MemRead_EX & ex_wr &
              ((useRn_ID & (Rn_ID == Rd_EX)) | (useRm_ID & (Rm_ID == Rd_EX)));
    br_haz  = early_ID &
              ((ex_wr & (Rm_ID == Rd_EX)) | (mem_wr & (Rm_ID == Rd_MEM)));
    state_d = S_RUN;
    if (halt_req)    state_d = S_HALT;
    else if (br_haz) state_d = S_STALL_BR;
    else if (lu_haz) state_d = S_STALL_LU;
  end

  // Pipeline control outputs follow the decision made this cycle.
  always_comb begin
    flush_run    = (state_d == S_RUN) & taken_ID & FLUSH_EN;
    pc_write     = (state_d == S_RUN);
    if_id_write  = (state_d == S_RUN);
    id_ex_bubble = (state_d != S_RUN);
    if_id_flush  = flush_run;
    if (reset) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
    end
  end

  // Counter next values; a cycle is counted once even if both hazards hit.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_d == S_STALL_LU) || (state_d == S_STALL_BR))
      stall_cnt_d = sat_inc(stall_cnt_q);
    if (flush_run)
      flush_cnt_d = sat_inc(flush_cnt_q);
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: two instances (no delay slot with 3-bit
// counters, delay slot with 32-bit counters) share the same stimulus.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, halt_req, useRn_ID, useRm_ID, early_ID, taken_ID;
  logic [4:0] Rn_ID, Rm_ID, Rd_EX, Rd_MEM;
  logic       RegWrite_EX, MemRead_EX, RegWrite_MEM;

  logic        pc0, ifw0, bub0, fl0, pc1, ifw1, bub1, fl1;
  logic [1:0]  st0, st1;
  logic [2:0]  sc0_o, fc0_o;
  logic [31:0] sc1_o, fc1_o;

  hazard_ctrl #(.DELAY_SLOT(0), .CNT_W(3)) dut0 (
    .clk(clk), .reset(reset), .halt_req(halt_req),
    .Rn_ID(Rn_ID), .Rm_ID(Rm_ID), .useRn_ID(useRn_ID), .useRm_ID(useRm_ID),
    .early_ID(early_ID), .taken_ID(taken_ID),
    .Rd_EX(Rd_EX), .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX),
    .Rd_MEM(Rd_MEM), .RegWrite_MEM(RegWrite_MEM),
    .pc_write(pc0), .if_id_write(ifw0), .id_ex_bubble(bub0), .if_id_flush(fl0),
    .state(st0), .stall_cnt(sc0_o), .flush_cnt(fc0_o));

  hazard_ctrl #(.DELAY_SLOT(1), .CNT_W(32)) dut1 (
    .clk(clk), .reset(reset), .halt_req(halt_req),
    .Rn_ID(Rn_ID), .Rm_ID(Rm_ID), .useRn_ID(useRn_ID), .useRm_ID(useRm_ID),
    .early_ID(early_ID), .taken_ID(taken_ID),
    .Rd_EX(Rd_EX), .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX),
    .Rd_MEM(Rd_MEM), .RegWrite_MEM(RegWrite_MEM),
    .pc_write(pc1), .if_id_write(ifw1), .id_ex_bubble(bub1), .if_id_flush(fl1),
    .state(st1), .stall_cnt(sc1_o), .flush_cnt(fc1_o));

  int tests = 0;
  int fails = 0;

  // Reference state: registered FSM state and counter values.
  int     m_state;
  longint m_sc0, m_fc0, m_sc1, m_fc1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decision from the hazard rules: 0 RUN, 1 load-use, 2 branch operand, 3 halt.
  function automatic int decide();
    bit ex_prod  = RegWrite_EX  && (Rd_EX  != 5'd31);
    bit mem_prod = RegWrite_MEM && (Rd_MEM != 5'd31);
    bit lu = MemRead_EX && ex_prod &&
             ((useRn_ID && Rn_ID == Rd_EX) || (useRm_ID && Rm_ID == Rd_EX));
    bit br = early_ID && ((ex_prod && Rm_ID == Rd_EX) || (mem_prod && Rm_ID == Rd_MEM));
    if (halt_req) return 3;
    if (br) return 2;
    if (lu) return 1;
    return 0;
  endfunction

  function automatic longint sat(input longint v, input longint maxv);
    return (v < maxv) ? v + 1 : maxv;
  endfunction

  task automatic idle();
    reset = 0; halt_req = 0; useRn_ID = 0; useRm_ID = 0; early_ID = 0; taken_ID = 0;
    Rn_ID = 0; Rm_ID = 0; Rd_EX = 0; Rd_MEM = 0;
    RegWrite_EX = 0; MemRead_EX = 0; RegWrite_MEM = 0;
  endtask

  // One cycle: check combinational outputs against the decision, clock,
  // then check the registered state and counters.
  task automatic step(input string tag);
    int  d;
    bit  run, fl_exp0;
    #1;
    d       = decide();
    run     = (d == 0);
    fl_exp0 = run && taken_ID;
    if (reset) begin
      chk({tag, ".pc"},    {30'd0, pc0,  pc1},  32'd3);
      chk({tag, ".ifw"},   {30'd0, ifw0, ifw1}, 32'd3);
      chk({tag, ".bub"},   {30'd0, bub0, bub1}, 32'd3);
      chk({tag, ".flush"}, {30'd0, fl0,  fl1},  32'd3);
    end else begin
      chk({tag, ".pc"},    {30'd0, pc0,  pc1},  run ? 32'd3 : 32'd0);
      chk({tag, ".ifw"},   {30'd0, ifw0, ifw1}, run ? 32'd3 : 32'd0);
      chk({tag, ".bub"},   {30'd0, bub0, bub1}, run ? 32'd0 : 32'd3);
      chk({tag, ".flush"}, {30'd0, fl0,  fl1},  {30'd0, fl_exp0, 1'b0});
    end
    @(posedge clk);
    if (reset) begin
      m_state = 0; m_sc0 = 0; m_fc0 = 0; m_sc1 = 0; m_fc1 = 0;
    end else begin
      m_state = d;
      if (d == 1 || d == 2) begin
        m_sc0 = sat(m_sc0, 7);
        m_sc1 = sat(m_sc1, 64'hFFFF_FFFF);
      end
      if (fl_exp0) m_fc0 = sat(m_fc0, 7);
    end
    #1;
    chk({tag, ".state0"}, {30'd0, st0}, m_state);
    chk({tag, ".state1"}, {30'd0, st1}, m_state);
    chk({tag, ".scnt0"},  {29'd0, sc0_o}, 32'(m_sc0));
    chk({tag, ".fcnt0"},  {29'd0, fc0_o}, 32'(m_fc0));
    chk({tag, ".scnt1"},  sc1_o, 32'(m_sc1));
    chk({tag, ".fcnt1"},  fc1_o, 32'(m_fc1));
  endtask

  task automatic do_reset();
    idle(); reset = 1;
    step("rst");
    idle();
  endtask

  function automatic logic [4:0] pick_reg();
    int r = $urandom_range(0, 4);
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    m_state = 0; m_sc0 = 0; m_fc0 = 0; m_sc1 = 0; m_fc1 = 0;
    idle(); reset = 1;
    @(posedge clk); #1;
    step("rst0");
    idle();
    chk("reset.state", {30'd0, st1}, 32'd0);
    chk("reset.stall_cnt", sc1_o, 32'd0);

    // Load X1 in EX, dependent ADD in ID: one stall, then RUN.
    MemRead_EX = 1; RegWrite_EX = 1; Rd_EX = 1; Rn_ID = 1; useRn_ID = 1;
    step("lu1");
    chk("lu1.state_is_lu", {30'd0, st1}, 32'd1);
    idle(); RegWrite_MEM = 1; Rd_MEM = 1; Rn_ID = 1; useRn_ID = 1;
    step("lu2");
    chk("lu.stall_cnt", sc1_o, 32'd1);

    // Same with XZR as destination: no stall.
    do_reset();
    MemRead_EX = 1; RegWrite_EX = 1; Rd_EX = 31; Rn_ID = 31; useRn_ID = 1;
    step("xzr");
    chk("xzr.stall_cnt", sc1_o, 32'd0);

    // ALU producer directly ahead of BR: two STALL_BR cycles.
    do_reset();
    RegWrite_EX = 1; Rd_EX = 5; early_ID = 1; Rm_ID = 5; useRm_ID = 1;
    step("br1");
    idle(); RegWrite_MEM = 1; Rd_MEM = 5; early_ID = 1; Rm_ID = 5; useRm_ID = 1;
    step("br2");
    chk("br2.state", {30'd0, st1}, 32'd2);
    idle(); early_ID = 1; Rm_ID = 5; useRm_ID = 1;
    step("br3");
    chk("br.stall_cnt", sc1_o, 32'd2);

    // Taken branch with no hazard: flush only without delay slot.
    do_reset();
    taken_ID = 1;
    step("flush");
    chk("flush.cnt_nods", {29'd0, fc0_o}, 32'd1);
    chk("flush.cnt_ds", fc1_o, 32'd0);

    // Both hazards together: STALL_BR wins, single count.
    do_reset();
    MemRead_EX = 1; RegWrite_EX = 1; Rd_EX = 2; Rn_ID = 2; useRn_ID = 1;
    early_ID = 1; Rm_ID = 2; useRm_ID = 1;
    step("both");
    chk("both.stall_cnt", sc1_o, 32'd1);

    // Halt over a load-use hazard, then release into one STALL_LU cycle.
    do_reset();
    MemRead_EX = 1; RegWrite_EX = 1; Rd_EX = 3; Rm_ID = 3; useRm_ID = 1; halt_req = 1;
    for (int i = 0; i < 5; i++) step("halt");
    chk("halt.state", {30'd0, st1}, 32'd3);
    chk("halt.stall_cnt", sc1_o, 32'd0);
    halt_req = 0;
    step("unhalt");
    chk("unhalt.state", {30'd0, st1}, 32'd1);
    chk("unhalt.stall_cnt", sc1_o, 32'd1);

    // Saturation on the 3-bit instance, then reset during STALL_BR.
    for (int i = 0; i < 9; i++) step("sat");
    chk("sat.stall_cnt", {29'd0, sc0_o}, 32'd7);
    idle(); RegWrite_EX = 1; Rd_EX = 4; early_ID = 1; Rm_ID = 4;
    step("brsat");
    chk("brsat.stall_cnt", {29'd0, sc0_o}, 32'd7);
    reset = 1;
    step("rst_br");
    chk("rst_br.state", {30'd0, st0}, 32'd0);
    chk("rst_br.stall_cnt", {29'd0, sc0_o}, 32'd0);
    idle();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 49) == 0);
      halt_req     = ($urandom_range(0, 7) == 0);
      Rn_ID        = pick_reg();
      Rm_ID        = pick_reg();
      Rd_EX        = pick_reg();
      Rd_MEM       = pick_reg();
      useRn_ID     = 1'($urandom);
      useRm_ID     = 1'($urandom);
      early_ID     = 1'($urandom);
      taken_ID     = 1'($urandom);
      RegWrite_EX  = 1'($urandom);
      MemRead_EX   = 1'($urandom);
      RegWrite_MEM = 1'($urandom);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
